// File: rtl/hdlc_pkg.sv
// hdlc_pkg: shared types and helpers for the HDLC receive deframer.
//   state_t           : deframer state (HUNT, FRAME, ABORT)
//   DEFAULT_STUFF_RUN : ones-run length that triggers a stuffed zero
//   cnt_w()           : bit width needed to hold a counter value 0..max_val
package hdlc_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        FRAME = 2'd1,
        ABORT = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_STUFF_RUN = 5;

    // Width of a counter that must reach max_val; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hdlc_bit_delay.sv
// hdlc_bit_delay: small FIFO-ordered bit delay line.
//   clk, reset   : clock, synchronous active-high reset
//   push, din    : append din; when full, the oldest bit is committed
//   flush        : drop every stored bit (has priority over push)
//   commit       : combinational, high in the cycle a push overflows the line
//   commit_bit   : combinational, the oldest bit being committed
module hdlc_bit_delay
    import hdlc_pkg::*;
#(
    parameter int unsigned DEPTH = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic din,
    input  logic flush,
    output logic commit,
    output logic commit_bit
);

    localparam int unsigned CNT_W = cnt_w(DEPTH);

    // bits_q[0] is always the oldest entry
    logic [DEPTH-1:0] bits_q, bits_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Occupancy and storage update
    always_comb begin
        bits_d     = bits_q;
        cnt_d      = cnt_q;
        commit     = 1'b0;
        commit_bit = bits_q[0];
        if (flush) begin
            cnt_d = '0;
        end else if (push) begin
            if (cnt_q == CNT_W'(DEPTH)) begin
                commit = 1'b1;
                bits_d = {din, bits_q[DEPTH-1:1]};
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        bits_d[i] = din;
                    end
                end
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bits_q <= '0;
            cnt_q  <= '0;
        end else begin
            bits_q <= bits_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/hdlc_rx_deframer.sv
// hdlc_rx_deframer: HDLC receive deframer (flag/stuff/abort detection,
// destuffing and LSB-first word assembly).
//   clk, reset        : clock, synchronous active-high reset
//   din_valid, din    : qualified serial line bit
//   data, data_valid  : assembled word (first bit in bit 0), one-cycle strobe
//   sof               : with the first data_valid of a frame
//   eof, frame_err    : closing flag of a non-empty frame; residue != 0
//   disc, flag        : stuffed zero removed; flag detected (pulses)
//   abort             : level, high while in the ABORT state
module hdlc_rx_deframer
    import hdlc_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned STUFF_RUN = DEFAULT_STUFF_RUN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              din_valid,
    input  logic              din,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              sof,
    output logic              eof,
    output logic              frame_err,
    output logic              disc,
    output logic              flag,
    output logic              abort
);

    localparam int unsigned ONES_MAX = STUFF_RUN + 2;
    localparam int unsigned ONES_W   = cnt_w(ONES_MAX);
    localparam int unsigned BIT_W    = cnt_w(DATA_W - 1);
    localparam int unsigned DEPTH    = STUFF_RUN + 2;

    state_t              state_q, state_d;
    logic [ONES_W-1:0]   ones_q, ones_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   sr_q, sr_d;
    logic                emitted_q, emitted_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                data_valid_q, data_valid_d;
    logic                sof_q, sof_d;
    logic                eof_q, eof_d;
    logic                frame_err_q, frame_err_d;
    logic                disc_q, disc_d;
    logic                flag_q, flag_d;
    logic                abort_q, abort_d;

    logic                push_c;
    logic                flush_c;
    logic                commit;
    logic                commit_bit;

    // Holds back the last STUFF_RUN+2 candidates so a closing flag never reaches the assembler
    hdlc_bit_delay #(
        .DEPTH (DEPTH)
    ) u_delay (
        .clk        (clk),
        .reset      (reset),
        .push       (push_c),
        .din        (din),
        .flush      (flush_c),
        .commit     (commit),
        .commit_bit (commit_bit)
    );

    // Bit classification, state transitions and word assembly
    always_comb begin
        state_d      = state_q;
        ones_d       = ones_q;
        bit_cnt_d    = bit_cnt_q;
        sr_d         = sr_q;
        emitted_d    = emitted_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        sof_d        = 1'b0;
        eof_d        = 1'b0;
        frame_err_d  = 1'b0;
        disc_d       = 1'b0;
        flag_d       = 1'b0;
        push_c       = 1'b0;
        flush_c      = 1'b0;

        if (din_valid) begin
            if (din) begin
                if (state_q == ABORT) begin
                    ones_d = ONES_W'(ONES_MAX);
                end else if (ones_q == ONES_W'(STUFF_RUN + 1)) begin
                    state_d   = ABORT;
                    ones_d    = ONES_W'(ONES_MAX);
                    flush_c   = 1'b1;
                    bit_cnt_d = '0;
                    emitted_d = 1'b0;
                end else begin
                    ones_d = ones_q + ONES_W'(1);
                    push_c = (state_q == FRAME);
                end
            end else begin
                ones_d = '0;
                if (state_q == ABORT) begin
                    state_d = HUNT;
                end else if (ones_q == ONES_W'(STUFF_RUN)) begin
                    disc_d = 1'b1;
                end else if (ones_q == ONES_W'(STUFF_RUN + 1)) begin
                    // The closing zero may also open the next flag; nothing extra to do
                    flag_d  = 1'b1;
                    flush_c = 1'b1;
                    if ((state_q == FRAME) && emitted_q) begin
                        eof_d       = 1'b1;
                        frame_err_d = (bit_cnt_q != '0);
                    end
                    state_d   = FRAME;
                    bit_cnt_d = '0;
                    emitted_d = 1'b0;
                end else begin
                    push_c = (state_q == FRAME);
                end
            end
        end

        // Commits only happen on a push, so never alongside a flag or abort
        if (commit) begin
            sr_d = {commit_bit, sr_q[DATA_W-1:1]};
            if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
                data_d       = sr_d;
                data_valid_d = 1'b1;
                sof_d        = ~emitted_q;
                emitted_d    = 1'b1;
                bit_cnt_d    = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
        end

        abort_d = (state_d == ABORT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= HUNT;
            ones_q       <= '0;
            bit_cnt_q    <= '0;
            sr_q         <= '0;
            emitted_q    <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
            frame_err_q  <= 1'b0;
            disc_q       <= 1'b0;
            flag_q       <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ones_q       <= ones_d;
            bit_cnt_q    <= bit_cnt_d;
            sr_q         <= sr_d;
            emitted_q    <= emitted_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            sof_q        <= sof_d;
            eof_q        <= eof_d;
            frame_err_q  <= frame_err_d;
            disc_q       <= disc_d;
            flag_q       <= flag_d;
            abort_q      <= abort_d;
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign sof        = sof_q;
    assign eof        = eof_q;
    assign frame_err  = frame_err_q;
    assign disc       = disc_q;
    assign flag       = flag_q;
    assign abort      = abort_q;

endmodule
